// File: rtl/globals_pkg.sv
// Shared types and constants for the CAPI tag allocator and its neighbours.
package globals_pkg;

    // Number of tag slots; tag 0 is reserved and never issued.
    localparam int TAG_COUNT   = 256;
    // Width of a compute-unit identifier.
    localparam int CU_ID_RANGE = 8;

    typedef logic [7:0]             tag_t;
    typedef logic [CU_ID_RANGE-1:0] cu_id_t;

    localparam tag_t   INVALID_TAG = '0;
    localparam cu_id_t INVALID_ID  = '0;
    // Highest usable tag, i.e. the last one written into the free list.
    localparam tag_t   LAST_TAG    = tag_t'(TAG_COUNT - 1);

endpackage

// File: rtl/tag_free_fifo.sv
// Show-ahead circular free list of tags. The head is held in a register so
// the consumer sees the next tag in the same cycle it is needed; the array
// is read one cycle early at the post-pop read pointer.
module tag_free_fifo
    import globals_pkg::*;
#(
    parameter int DEPTH = TAG_COUNT
)
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  tag_t                   push_data,
    input  logic                   pop,
    output tag_t                   head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);

    tag_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] rd_ptr_next;
    logic [PW:0]   count_reg;
    logic [PW:0]   count_next;
    logic          push_ok;
    logic          pop_ok;
    tag_t          head_mem_reg;
    tag_t          bypass_data_reg;
    logic          bypass_reg;

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == (PW+1)'(DEPTH));
    assign push_ok     = push && !full;
    assign pop_ok      = pop && !empty;
    assign rd_ptr_next = rd_ptr_reg + PW'(pop_ok);
    assign count_next  = count_reg + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    assign count       = count_reg;

    // When the word being written is the one that becomes the head, the
    // array read would return stale data, so the written word is forwarded.
    assign head = bypass_reg ? bypass_data_reg : head_mem_reg;

    // Storage array: write at the tail, registered read of the next head.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
        head_mem_reg <= mem[rd_ptr_next];
    end

    // Pointers, occupancy and write-to-head forwarding control.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            bypass_reg      <= 1'b0;
            bypass_data_reg <= INVALID_TAG;
        end else begin
            wr_ptr_reg      <= wr_ptr_reg + PW'(push_ok);
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            bypass_reg      <= push_ok && (wr_ptr_reg == rd_ptr_next);
            bypass_data_reg <= push_data;
        end
    end

endmodule

// File: rtl/tag_control.sv
// CAPI command tag allocator: hands out free tags to the command arbiter,
// remembers which compute unit owns each tag, and maps returning response
// tags back to their owner while recycling the tag.
module tag_control
    import globals_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       alloc_valid_in,
    input  cu_id_t     alloc_cu_id_in,
    output logic       tag_valid_out,
    output tag_t       tag_out,
    input  logic       rsp_valid_in,
    input  tag_t       rsp_tag_in,
    output logic       rsp_valid_out,
    output tag_t       rsp_tag_out,
    output cu_id_t     rsp_cu_id_out,
    output logic [8:0] tags_in_use_out,
    output logic       init_done_out,
    output logic [1:0] error_out
);

    typedef enum logic [1:0] {
        RESET,
        INIT,
        READY
    } state_t;

    state_t               state_reg;
    tag_t                 init_tag_reg;
    logic                 init_done_reg;
    logic                 rsp_valid_reg;
    tag_t                 rsp_tag_reg;
    cu_id_t               rsp_cu_id_reg;
    logic [8:0]           tags_in_use_reg;
    logic [1:0]           error_reg;
    logic [TAG_COUNT-1:0] busy_reg;
    logic [TAG_COUNT-1:0] busy_set;
    logic [TAG_COUNT-1:0] busy_clr;
    cu_id_t               cu_table [TAG_COUNT];

    logic       ready;
    logic       fifo_push;
    tag_t       fifo_push_data;
    tag_t       fifo_head;
    logic [8:0] free_count;
    logic       fifo_empty;
    logic       fifo_full;
    logic       alloc_fire;
    logic       alloc_err;
    logic       rel_fire;
    logic       rel_err;

    assign ready = (state_reg == READY);

    // An allocate is only accepted against a non-empty list in READY.
    assign alloc_fire = ready && alloc_valid_in && !fifo_empty;
    assign alloc_err  = ready && alloc_valid_in && fifo_empty;

    // A release must name an outstanding, non-reserved tag. A tag issued in
    // this same cycle is not yet busy, so releasing it is rejected. The list
    // can never be full while any tag is busy; the full term is defensive.
    assign rel_fire = ready && rsp_valid_in && (rsp_tag_in != INVALID_TAG)
                      && busy_reg[rsp_tag_in] && !fifo_full;
    assign rel_err  = ready && rsp_valid_in && !rel_fire;

    // During INIT the counter seeds the list; afterwards released tags go in.
    assign fifo_push      = (state_reg == INIT) || rel_fire;
    assign fifo_push_data = (state_reg == INIT) ? init_tag_reg : rsp_tag_in;

    // The head is masked while nothing is allocatable so the port never
    // shows a stale or uninitialised entry.
    assign tag_valid_out   = ready && (free_count != '0);
    assign tag_out         = tag_valid_out ? fifo_head : INVALID_TAG;
    assign rsp_valid_out   = rsp_valid_reg;
    assign rsp_tag_out     = rsp_tag_reg;
    assign rsp_cu_id_out   = rsp_cu_id_reg;
    assign tags_in_use_out = tags_in_use_reg;
    assign init_done_out   = init_done_reg;
    assign error_out       = error_reg;

    tag_free_fifo #(
        .DEPTH (TAG_COUNT)
    ) u_free_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (alloc_fire),
        .head      (fifo_head),
        .count     (free_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Per-tag set/clear strobes decoded from the issued and released tags.
    for (genvar gi = 0; gi < TAG_COUNT; gi++) begin : g_busy_decode
        assign busy_set[gi] = alloc_fire && (fifo_head == tag_t'(gi));
        assign busy_clr[gi] = rel_fire && (rsp_tag_in == tag_t'(gi));
    end

    // Busy vector: a tag is busy from its issue until its accepted release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= (busy_reg | busy_set) & ~busy_clr;
        end
    end

    // Owner table: record the requesting compute unit against the issued tag.
    always_ff @(posedge clock) begin
        if (alloc_fire) begin
            cu_table[fifo_head] <= alloc_cu_id_in;
        end
    end

    // Control FSM plus registered response, in-use count and sticky errors.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= RESET;
            init_tag_reg    <= tag_t'(1);
            init_done_reg   <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_tag_reg     <= INVALID_TAG;
            rsp_cu_id_reg   <= INVALID_ID;
            tags_in_use_reg <= '0;
            error_reg       <= '0;
        end else begin
            rsp_valid_reg <= rel_fire;
            case (state_reg)
                RESET: begin
                    state_reg    <= INIT;
                    init_tag_reg <= tag_t'(1);
                end
                INIT: begin
                    init_tag_reg <= init_tag_reg + tag_t'(1);
                    if (init_tag_reg == LAST_TAG) begin
                        state_reg     <= READY;
                        init_done_reg <= 1'b1;
                    end
                end
                READY: begin
                    if (rel_fire) begin
                        rsp_tag_reg   <= rsp_tag_in;
                        rsp_cu_id_reg <= cu_table[rsp_tag_in];
                    end
                    tags_in_use_reg <= tags_in_use_reg + 9'(alloc_fire) - 9'(rel_fire);
                    if (alloc_err) begin
                        error_reg[0] <= 1'b1;
                    end
                    if (rel_err) begin
                        error_reg[1] <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tag_control.sv
// Self-checking bench for tag_control: directed scenarios plus a randomized
// allocate/release mix checked against a queue-based model of the free list.
module tb_tag_control;
    import globals_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       alloc_valid_in;
    cu_id_t     alloc_cu_id_in;
    logic       tag_valid_out;
    tag_t       tag_out;
    logic       rsp_valid_in;
    tag_t       rsp_tag_in;
    logic       rsp_valid_out;
    tag_t       rsp_tag_out;
    cu_id_t     rsp_cu_id_out;
    logic [8:0] tags_in_use_out;
    logic       init_done_out;
    logic [1:0] error_out;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int       free_q[$];
    bit       m_busy[256];
    int       m_owner[256];
    int       m_in_use;
    bit [1:0] m_err;
    bit       m_rsp_valid;
    int       m_rsp_tag;
    int       m_rsp_cu;

    tag_control dut (
        .clock           (clock),
        .reset           (reset),
        .alloc_valid_in  (alloc_valid_in),
        .alloc_cu_id_in  (alloc_cu_id_in),
        .tag_valid_out   (tag_valid_out),
        .tag_out         (tag_out),
        .rsp_valid_in    (rsp_valid_in),
        .rsp_tag_in      (rsp_tag_in),
        .rsp_valid_out   (rsp_valid_out),
        .rsp_tag_out     (rsp_tag_out),
        .rsp_cu_id_out   (rsp_cu_id_out),
        .tags_in_use_out (tags_in_use_out),
        .init_done_out   (init_done_out),
        .error_out       (error_out)
    );

    always #5 clock = ~clock;

    task automatic model_init();
        free_q.delete();
        for (int i = 1; i < 256; i++) free_q.push_back(i);
        for (int i = 0; i < 256; i++) begin
            m_busy[i]  = 1'b0;
            m_owner[i] = 0;
        end
        m_in_use    = 0;
        m_err       = 2'b00;
        m_rsp_valid = 1'b0;
        m_rsp_tag   = 0;
        m_rsp_cu    = 0;
    endtask

    function automatic int model_head();
        return (free_q.size() > 0) ? free_q[0] : 0;
    endfunction

    // Drives one cycle of stimulus, advances the model, and logs the result.
    task automatic drive_cycle(input bit a, input int cu, input bit r, input int rt);
        bit rel_ok;
        int t;
        alloc_valid_in = a;
        alloc_cu_id_in = cu_id_t'(cu);
        rsp_valid_in   = r;
        rsp_tag_in     = tag_t'(rt);
        rel_ok = r && (rt != 0) && m_busy[rt];
        if (a) begin
            if (free_q.size() > 0) begin
                t = free_q.pop_front();
                m_busy[t]  = 1'b1;
                m_owner[t] = cu;
                m_in_use++;
            end else begin
                m_err[0] = 1'b1;
            end
        end
        m_rsp_valid = rel_ok;
        if (r) begin
            if (rel_ok) begin
                m_busy[rt] = 1'b0;
                free_q.push_back(rt);
                m_in_use--;
                m_rsp_tag = rt;
                m_rsp_cu  = m_owner[rt];
            end else begin
                m_err[1] = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        alloc_valid_in = 1'b0;
        rsp_valid_in   = 1'b0;
        $display("txn a=%0b cu=%02h r=%0b rt=%0d | tag_v=%0b tag=%0d rsp_v=%0b rsp_tag=%0d rsp_cu=%02h in_use=%0d err=%b",
                 a, cu, r, rt, tag_valid_out, tag_out, rsp_valid_out, rsp_tag_out,
                 rsp_cu_id_out, tags_in_use_out, error_out);
    endtask

    // Pulses reset and waits out the known initialisation time.
    task automatic reinit();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (256) @(posedge clock);
        #1;
        model_init();
    endtask

    task automatic test_reset();
        int  n;
        bit  early_valid;
        reset          = 1'b1;
        alloc_valid_in = 1'b0;
        alloc_cu_id_in = '0;
        rsp_valid_in   = 1'b0;
        rsp_tag_in     = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (tag_valid_out !== 1'b0) begin errors++; $display("FAIL reset_tag_valid got=%b want=0", tag_valid_out); end
        checks++; if (tag_out !== INVALID_TAG) begin errors++; $display("FAIL reset_tag_out got=%0d want=0", tag_out); end
        checks++; if (rsp_valid_out !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid_out); end
        checks++; if (rsp_tag_out !== INVALID_TAG) begin errors++; $display("FAIL reset_rsp_tag got=%0d want=0", rsp_tag_out); end
        checks++; if (rsp_cu_id_out !== INVALID_ID) begin errors++; $display("FAIL reset_rsp_cu got=%0h want=0", rsp_cu_id_out); end
        checks++; if (tags_in_use_out !== 9'd0) begin errors++; $display("FAIL reset_in_use got=%0d want=0", tags_in_use_out); end
        checks++; if (init_done_out !== 1'b0) begin errors++; $display("FAIL reset_init_done got=%b want=0", init_done_out); end
        checks++; if (error_out !== 2'b00) begin errors++; $display("FAIL reset_error got=%b want=00", error_out); end
        reset = 1'b0;
        n = 0;
        early_valid = 1'b0;
        while (n < 400) begin
            @(posedge clock);
            #1;
            n++;
            if (init_done_out === 1'b1) break;
            if (tag_valid_out !== 1'b0) early_valid = 1'b1;
        end
        checks++; if (n != 256) begin errors++; $display("FAIL init_latency got=%0d want=256 cycles", n); end
        checks++; if (early_valid) begin errors++; $display("FAIL init_tag_valid_early got=1 want=0 before READY"); end
        model_init();
        checks++; if (tag_valid_out !== 1'b1) begin errors++; $display("FAIL init_tag_valid got=%b want=1", tag_valid_out); end
        checks++; if (tag_out !== tag_t'(1)) begin errors++; $display("FAIL init_tag_out got=%0d want=1", tag_out); end
    endtask

    task automatic test_sequential();
        int cus[3] = '{3, 5, 7};
        for (int i = 0; i < 3; i++) begin
            checks++; if (tag_out !== tag_t'(i + 1)) begin errors++; $display("FAIL seq_tag_out got=%0d want=%0d", tag_out, i + 1); end
            drive_cycle(1'b1, cus[i], 1'b0, 0);
        end
        checks++; if (tags_in_use_out !== 9'd3) begin errors++; $display("FAIL seq_in_use got=%0d want=3", tags_in_use_out); end
        checks++; if (tag_out !== tag_t'(4)) begin errors++; $display("FAIL seq_next_tag got=%0d want=4", tag_out); end
    endtask

    task automatic test_release_and_exhaust();
        drive_cycle(1'b0, 0, 1'b1, 2);
        checks++; if (rsp_valid_out !== 1'b1) begin errors++; $display("FAIL rel_valid got=%b want=1", rsp_valid_out); end
        checks++; if (rsp_tag_out !== tag_t'(2)) begin errors++; $display("FAIL rel_tag got=%0d want=2", rsp_tag_out); end
        checks++; if (rsp_cu_id_out !== cu_id_t'(8'h05)) begin errors++; $display("FAIL rel_cu got=%0h want=05", rsp_cu_id_out); end
        checks++; if (tags_in_use_out !== 9'd2) begin errors++; $display("FAIL rel_in_use got=%0d want=2", tags_in_use_out); end
        drive_cycle(1'b0, 0, 1'b0, 0);
        checks++; if (rsp_valid_out !== 1'b0) begin errors++; $display("FAIL rel_pulse got=%b want=0", rsp_valid_out); end
        // tags 4..255 must come out before the recycled tag 2
        for (int t = 4; t < 256; t++) begin
            checks++; if (tag_out !== tag_t'(t)) begin errors++; $display("FAIL exh_order got=%0d want=%0d", tag_out, t); end
            drive_cycle(1'b1, $urandom_range(0, 255), 1'b0, 0);
        end
        checks++; if (tag_out !== tag_t'(2)) begin errors++; $display("FAIL exh_reissue got=%0d want=2", tag_out); end
        drive_cycle(1'b1, 8'h22, 1'b0, 0);
        checks++; if (tag_valid_out !== 1'b0) begin errors++; $display("FAIL exh_tag_valid got=%b want=0", tag_valid_out); end
        checks++; if (tags_in_use_out !== 9'd255) begin errors++; $display("FAIL exh_in_use got=%0d want=255", tags_in_use_out); end
        checks++; if (error_out !== 2'b00) begin errors++; $display("FAIL exh_err_before got=%b want=00", error_out); end
        drive_cycle(1'b1, 8'h33, 1'b0, 0);
        checks++; if (error_out !== 2'b01) begin errors++; $display("FAIL exh_alloc_empty_err got=%b want=01", error_out); end
        checks++; if (tags_in_use_out !== 9'd255) begin errors++; $display("FAIL exh_in_use_drop got=%0d want=255", tags_in_use_out); end
        // release arriving with an empty list: the allocate still fails
        drive_cycle(1'b1, 8'h44, 1'b1, 7);
        checks++; if (rsp_valid_out !== 1'b1 || rsp_tag_out !== tag_t'(7)) begin errors++; $display("FAIL exh_rel7 got v=%b tag=%0d want v=1 tag=7", rsp_valid_out, rsp_tag_out); end
        checks++; if (rsp_cu_id_out !== cu_id_t'(m_rsp_cu)) begin errors++; $display("FAIL exh_rel7_cu got=%0h want=%0h", rsp_cu_id_out, m_rsp_cu); end
        checks++; if (tags_in_use_out !== 9'd254) begin errors++; $display("FAIL exh_rel7_in_use got=%0d want=254", tags_in_use_out); end
        checks++; if (tag_valid_out !== 1'b1 || tag_out !== tag_t'(7)) begin errors++; $display("FAIL exh_tag7 got v=%b tag=%0d want v=1 tag=7", tag_valid_out, tag_out); end
    endtask

    task automatic test_simultaneous();
        reinit();
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 8'h10 + i, 1'b0, 0);
        checks++; if (tag_out !== tag_t'(11)) begin errors++; $display("FAIL sim_pre_tag got=%0d want=11", tag_out); end
        drive_cycle(1'b1, 8'hAA, 1'b1, 1);
        checks++; if (tags_in_use_out !== 9'd10) begin errors++; $display("FAIL sim_in_use got=%0d want=10", tags_in_use_out); end
        checks++; if (rsp_valid_out !== 1'b1 || rsp_tag_out !== tag_t'(1)) begin errors++; $display("FAIL sim_rsp got v=%b tag=%0d want v=1 tag=1", rsp_valid_out, rsp_tag_out); end
        checks++; if (rsp_cu_id_out !== cu_id_t'(8'h10)) begin errors++; $display("FAIL sim_rsp_cu got=%0h want=10", rsp_cu_id_out); end
        checks++; if (tag_out !== tag_t'(12)) begin errors++; $display("FAIL sim_next_tag got=%0d want=12", tag_out); end
        drive_cycle(1'b0, 0, 1'b1, 1);
        checks++; if (rsp_valid_out !== 1'b0) begin errors++; $display("FAIL dbl_rsp_valid got=%b want=0", rsp_valid_out); end
        checks++; if (error_out !== 2'b10) begin errors++; $display("FAIL dbl_err got=%b want=10", error_out); end
        checks++; if (tags_in_use_out !== 9'd10) begin errors++; $display("FAIL dbl_in_use got=%0d want=10", tags_in_use_out); end
        // back-to-back releases, one response pulse per cycle
        for (int t = 2; t <= 4; t++) begin
            drive_cycle(1'b0, 0, 1'b1, t);
            checks++; if (rsp_valid_out !== 1'b1 || rsp_tag_out !== tag_t'(t)) begin errors++; $display("FAIL b2b_rsp got v=%b tag=%0d want v=1 tag=%0d", rsp_valid_out, rsp_tag_out, t); end
            checks++; if (rsp_cu_id_out !== cu_id_t'(8'h10 + t - 1)) begin errors++; $display("FAIL b2b_cu got=%0h want=%0h", rsp_cu_id_out, 8'h10 + t - 1); end
        end
        checks++; if (tags_in_use_out !== 9'd7) begin errors++; $display("FAIL b2b_in_use got=%0d want=7", tags_in_use_out); end
    endtask

    task automatic test_random();
        int busy_list[$];
        bit a, r;
        int rt;
        for (int c = 0; c < 300; c++) begin
            checks++; if (tag_valid_out !== (free_q.size() > 0)) begin errors++; $display("FAIL rnd_tag_valid got=%b want=%b", tag_valid_out, free_q.size() > 0); end
            checks++; if (tag_out !== tag_t'(model_head())) begin errors++; $display("FAIL rnd_tag_out got=%0d want=%0d", tag_out, model_head()); end
            busy_list.delete();
            for (int i = 1; i < 256; i++) if (m_busy[i]) busy_list.push_back(i);
            a = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            if (busy_list.size() > 0 && $urandom_range(0, 99) < 85)
                rt = busy_list[$urandom_range(0, busy_list.size() - 1)];
            else
                rt = $urandom_range(0, 255);
            drive_cycle(a, $urandom_range(0, 255), r, rt);
            checks++; if (rsp_valid_out !== m_rsp_valid) begin errors++; $display("FAIL rnd_rsp_valid got=%b want=%b", rsp_valid_out, m_rsp_valid); end
            if (m_rsp_valid) begin
                checks++; if (rsp_tag_out !== tag_t'(m_rsp_tag) || rsp_cu_id_out !== cu_id_t'(m_rsp_cu)) begin errors++; $display("FAIL rnd_rsp got tag=%0d cu=%0h want tag=%0d cu=%0h", rsp_tag_out, rsp_cu_id_out, m_rsp_tag, m_rsp_cu); end
            end
            checks++; if (tags_in_use_out !== 9'(m_in_use)) begin errors++; $display("FAIL rnd_in_use got=%0d want=%0d", tags_in_use_out, m_in_use); end
            checks++; if (error_out !== m_err) begin errors++; $display("FAIL rnd_err got=%b want=%b", error_out, m_err); end
        end
    endtask

    task automatic test_reset_mid();
        reinit();
        for (int i = 0; i < 50; i++) drive_cycle(1'b1, $urandom_range(0, 255), 1'b0, 0);
        drive_cycle(1'b0, 0, 1'b1, 5);
        checks++; if (tags_in_use_out !== 9'd49 || rsp_valid_out !== 1'b1) begin errors++; $display("FAIL mid_pre got in_use=%0d v=%b want 49 1", tags_in_use_out, rsp_valid_out); end
        drive_cycle(1'b1, 0, 1'b0, 0);
        reset = 1'b1;
        #2;
        checks++; if (tag_valid_out !== 1'b0 || tag_out !== INVALID_TAG) begin errors++; $display("FAIL mid_tag got v=%b tag=%0d want 0 0", tag_valid_out, tag_out); end
        checks++; if (rsp_valid_out !== 1'b0 || rsp_tag_out !== INVALID_TAG || rsp_cu_id_out !== INVALID_ID) begin errors++; $display("FAIL mid_rsp got v=%b tag=%0d cu=%0h want 0 0 0", rsp_valid_out, rsp_tag_out, rsp_cu_id_out); end
        checks++; if (tags_in_use_out !== 9'd0 || init_done_out !== 1'b0 || error_out !== 2'b00) begin errors++; $display("FAIL mid_state got in_use=%0d done=%b err=%b want 0 0 00", tags_in_use_out, init_done_out, error_out); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (256) @(posedge clock);
        #1;
        model_init();
        checks++; if (init_done_out !== 1'b1) begin errors++; $display("FAIL mid_reinit_done got=%b want=1", init_done_out); end
        checks++; if (tag_out !== tag_t'(1) || tag_valid_out !== 1'b1) begin errors++; $display("FAIL mid_reinit_tag got tag=%0d v=%b want 1 1", tag_out, tag_valid_out); end
        checks++; if (tags_in_use_out !== 9'd0) begin errors++; $display("FAIL mid_reinit_in_use got=%0d want=0", tags_in_use_out); end
        drive_cycle(1'b0, 0, 1'b1, 1);
        checks++; if (rsp_valid_out !== 1'b0 || error_out !== 2'b10) begin errors++; $display("FAIL mid_forgotten got v=%b err=%b want 0 10", rsp_valid_out, error_out); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_release_and_exhaust();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tag_control.md
# tag_control

Allocates CAPI command tags to outgoing read/write commands and maps each response tag back to the issuing compute unit's `cu_id`. Sits between the command arbiter, which consumes tags, and the response demultiplexer, which consumes `cu_id`s. It maintains a free-tag circular list, a per-tag busy vector and a per-tag `cu_id` table.

## Interface
- `TAG_COUNT`, default 256: number of tag slots. Tag `INVALID_TAG` (0) is never issued, so 255 tags are usable.
- `CU_ID_RANGE`, default 8: width of `cu_id_t`.
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `alloc_valid_in`  in  1  consume the presented tag this cycle.
- `alloc_cu_id_in`  in  `CU_ID_RANGE`  ID of the requesting compute unit.
- `tag_valid_out`  out  1  `tag_out` is allocatable.
- `tag_out`  out  8  head of the free list (show-ahead).
- `rsp_valid_in`  in  1  a response has returned; its tag is released.
- `rsp_tag_in`  in  8  tag of the returning response.
- `rsp_valid_out`  out  1  lookup result valid.
- `rsp_tag_out`  out  8  echoed released tag.
- `rsp_cu_id_out`  out  `CU_ID_RANGE`  owner of the released tag.
- `tags_in_use_out`  out  9  count of outstanding tags.
- `init_done_out`  out  1  free list populated.
- `error_out`  out  2  sticky error bits: [0] alloc while empty, [1] bad release.

## Operation
- FSM states: `RESET` → `INIT` → `READY`.
  - `RESET` is entered asynchronously on `reset` and left on the first clock with `reset` low.
  - `INIT` writes tags 1..TAG_COUNT-1 into the free list, one per cycle, taking 255 cycles, then goes to `READY`.
- `init_done_out` asserts in the first `READY` cycle.
- Inputs are ignored outside `READY`.
- Free list: circular buffer of depth TAG_COUNT with 8-bit read/write pointers that wrap naturally, plus a 9-bit count.
- Allocate: `tag_valid_out = READY && count != 0`. On `alloc_valid_in && tag_valid_out`:
  - pop the head;
  - set `busy[tag]`;
  - write `cu_table[tag] <= alloc_cu_id_in`;
  - increment `tags_in_use_out`.
- Allocate while empty: `alloc_valid_in` with `tag_valid_out` low is dropped and sets `error_out[0]`.
- Release: on `rsp_valid_in` with `busy[rsp_tag_in]` set and `rsp_tag_in != 0`:
  - push `rsp_tag_in` at the tail;
  - clear its busy bit;
  - decrement the in-use count;
  - register `{rsp_tag_out, rsp_cu_id_out}`.
- Bad release: a release with the busy bit clear or tag 0 is dropped, sets `error_out[1]`, and produces no `rsp_valid_out`.
- Simultaneous allocate and release in one cycle: both take effect, and the count is unchanged.
  - The released tag goes to the tail, so it cannot be the tag popped in that cycle.
  - If the count is 0 and a release arrives, the allocate still fails in that cycle; the released tag is presented on the next cycle.
- Release of a tag allocated in the same cycle cannot occur: its busy bit is not yet set, so it is treated as a bad release.
- Width rules:
  - `tags_in_use_out` is 0..255.
  - The free count is 0..255, 9 bits wide, and never exceeds TAG_COUNT-1.

## Timing
- Reset values of all outputs:
  - `tag_valid_out` = 0, `tag_out` = `INVALID_TAG`;
  - `rsp_valid_out` = 0, `rsp_tag_out` = 0, `rsp_cu_id_out` = `INVALID_ID`;
  - `tags_in_use_out` = 0, `init_done_out` = 0, `error_out` = 0.
- Busy vector and pointers reset to 0. The table contents need no reset.
- `tag_out` and `tag_valid_out` are combinational from the head register and count; they are valid in the same cycle, with no request/grant latency.
- Pop, busy and table updates take effect at the clock edge where the allocate is accepted. The next tag is presented in the following cycle, so one allocate per cycle is sustainable.
- Release lookup latency is 1 cycle. `rsp_valid_out` is a single-cycle pulse per accepted release, and back-to-back releases are supported.
- Reset asserted mid-operation:
  - all state is cleared immediately;
  - outstanding tags are forgotten;
  - `INIT` reruns after reset deasserts.

## Structure
- `GLOBALS_PKG` holds `TAG_COUNT`, `INVALID_TAG`, `INVALID_ID` and `cu_id_t`.
- Add `typedef logic [0:7] tag_t` to `GLOBALS_PKG`.
- The FSM state enum stays local to the module.
- One sub-module, `tag_free_fifo`: show-ahead circular buffer with push/pop, count, empty and full. `tag_control` instantiates it and owns the FSM, busy vector, `cu_table` and error logic.

## Test plan
- Init: release `reset` → `init_done_out` rises 256 cycles later; `tag_out` = 1 and `tag_valid_out` = 1.
- Sequential allocate: three allocates with `cu_id` 0x03, 0x05, 0x07 → tags 1, 2, 3 issued; `tags_in_use_out` = 3.
- Release lookup: release tag 2 → next cycle `rsp_valid_out` = 1, `rsp_tag_out` = 2, `rsp_cu_id_out` = 0x05; in-use count = 2; tag 2 is reissued only after tags 4..255.
- Exhaust: 255 allocates → `tag_valid_out` = 0; a 256th allocate sets `error_out[0]`. Then release 7 → `tag_out` = 7 next cycle.
- Simultaneous: allocate and release (tag 1) in the same cycle with 10 tags outstanding → count stays 10; `rsp_cu_id_out` is correct. Double release of tag 1 sets `error_out[1]` with no `rsp_valid_out`.
- Reset mid-operation: with 50 tags outstanding, assert `reset` → all outputs return to reset values at once; after re-init the first tag is 1 and `tags_in_use_out` = 0.
